// File: rtl/symbol_row_renderer.sv
// symbol_row_renderer
//   Draws a horizontal row of N_SYM 32x32 game symbols (each scaled by
//   2^SCALE_LOG2) into a VGA pixel stream. Symbol codes live in a
//   double-buffered register file: host writes land in a shadow bank that
//   is copied to the live bank on frame_tick, so a row never tears.
//
//   Optional feature macro: SYMBOL_ROW_BLINK_EN
//     defined   -> frame counter, blink phase and highlight masking built
//     undefined -> hl_en / hl_idx are ignored, no slot is ever masked
//
//   Ports
//     clk, reset_n            pixel clock, asynchronous active-low reset
//     frame_tick              1-cycle pulse at start of vertical blank
//     top_left_x/y [9:0]      row origin, loaded on frame_tick
//     wr_en/wr_idx/wr_value   shadow-bank write port
//     hl_en/hl_idx            highlight control, loaded on frame_tick
//     pixel_valid/x/y         current pixel coordinate
//     out_valid, on, color    2-cycle delayed pixel result (RGB444)
//
//   Flow control: valid-only stream. Every cycle a pixel is accepted and
//   out_valid is pixel_valid delayed by exactly 2 cycles; there is no ready
//   and no stall. Invalid pixels still travel the pipe and emerge with
//   on=0 and color=0.
module symbol_row_renderer #(
  parameter int N_SYM        = 4,
  parameter int SCALE_LOG2   = 0,
  parameter int GAP          = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  top_left_x,
  input  logic [9:0]  top_left_y,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [2:0]  wr_value,
  input  logic        hl_en,
  input  logic [3:0]  hl_idx,
  input  logic        pixel_valid,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        out_valid,
  output logic        on,
  output logic [11:0] color
);

  localparam int F      = 32 << SCALE_LOG2;
  localparam int STRIDE = F + GAP;
  // Wide enough that no slot extent can wrap; slots past 1023 simply never hit.
  localparam int BW     = 13;

  // ---------------- register file ----------------
  logic [2:0] shadow_q    [N_SYM];
  logic [2:0] shadow_next [N_SYM];
  logic [2:0] live_q      [N_SYM];
  logic [9:0] ox_q, oy_q;
  logic       wr_ok;

  assign wr_ok = wr_en && (32'(wr_idx) < N_SYM);

  // A write in the frame_tick cycle is folded into the same commit.
  always_comb begin
    for (int k = 0; k < N_SYM; k++) begin
      shadow_next[k] = shadow_q[k];
      if (wr_ok && (wr_idx == 4'(k))) shadow_next[k] = wr_value;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_SYM; k++) begin
        shadow_q[k] <= 3'd7;
        live_q[k]   <= 3'd7;
      end
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      for (int k = 0; k < N_SYM; k++) begin
        shadow_q[k] <= shadow_next[k];
        if (frame_tick) live_q[k] <= shadow_next[k];
      end
      if (frame_tick) begin
        ox_q <= top_left_x;
        oy_q <= top_left_y;
      end
    end
  end

  // ---------------- blink / highlight ----------------
  logic [N_SYM-1:0] mask_vec;

`ifdef SYMBOL_ROW_BLINK_EN
  logic [7:0] blink_cnt_q;
  logic       blink_phase_q;
  logic       hl_en_q;
  logic [3:0] hl_idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      hl_en_q       <= 1'b0;
      hl_idx_q      <= '0;
    end else if (frame_tick) begin
      hl_en_q  <= hl_en;
      hl_idx_q <= hl_idx;
      if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 8'd1;
      end
    end
  end

  // An out-of-range hl_idx matches no k, so it masks nothing.
  always_comb begin
    for (int k = 0; k < N_SYM; k++)
      mask_vec[k] = blink_phase_q && hl_en_q && (hl_idx_q == 4'(k));
  end
`else
  logic unused_hl;
  assign unused_hl = ^{hl_en, hl_idx};
  assign mask_vec  = '0;
`endif

  // ---------------- stage 1: slot hit and local coordinates ----------------
  logic [BW-1:0] px_w, py_w, ox_w, oy_w, left_k, dx, dy;
  logic          y_in, hit, masked;
  logic [2:0]    hit_code;

  assign px_w = {3'b0, pixel_x};
  assign py_w = {3'b0, pixel_y};
  assign ox_w = {3'b0, ox_q};
  assign oy_w = {3'b0, oy_q};
  assign y_in = (py_w >= oy_w) && (py_w <= oy_w + BW'(F - 1));
  assign dy   = py_w - oy_w;

  always_comb begin
    hit      = 1'b0;
    masked   = 1'b0;
    hit_code = 3'd7;
    dx       = '0;
    left_k   = '0;
    for (int k = 0; k < N_SYM; k++) begin
      left_k = ox_w + BW'(k * STRIDE);
      if (y_in && (px_w >= left_k) && (px_w <= left_k + BW'(F - 1))) begin
        hit      = 1'b1;
        masked   = mask_vec[k];
        hit_code = live_q[k];
        dx       = px_w - left_k;
      end
    end
  end

  logic       s1_valid, s1_lit;
  logic [2:0] s1_code;
  logic [4:0] s1_r, s1_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_lit   <= 1'b0;
      s1_code  <= 3'd7;
      s1_r     <= '0;
      s1_c     <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_lit   <= pixel_valid && hit && !masked;
      s1_code  <= hit_code;
      s1_r     <= 5'(dy >> SCALE_LOG2);
      s1_c     <= 5'(dx >> SCALE_LOG2);
    end
  end

  // ---------------- stage 2: shape test ----------------
  function automatic logic diamond_hit(input logic [4:0] r, input logic [4:0] c);
    int ri, ci, d;
    ri = 32'(r);
    ci = 32'(c);
    d  = (ri <= 15) ? ri : 31 - ri;
    return (d >= 2) && (ci >= 17 - d) && (ci <= 14 + d);
  endfunction

  function automatic logic square_hit(input logic [4:0] r, input logic [4:0] c);
    return (r >= 5'd2) && (r <= 5'd29) && (c >= 5'd2) && (c <= 5'd29);
  endfunction

  // Column = central bar plus diamond-shaped caps and a diamond waist.
  function automatic logic column_hit(input logic [4:0] r, input logic [4:0] c);
    logic bar, cap_row;
    bar     = (r >= 5'd4) && (r <= 5'd27) && (c >= 5'd5) && (c <= 5'd26);
    cap_row = (r == 5'd2) || (r == 5'd3) || ((r >= 5'd13) && (r <= 5'd18)) ||
              (r == 5'd28) || (r == 5'd29);
    return bar || (cap_row && diamond_hit(r, c));
  endfunction

  logic        shape_lit;
  logic [11:0] shape_color;

  always_comb begin
    shape_lit   = 1'b0;
    shape_color = '0;
    case (s1_code)
      3'd0: begin shape_lit = square_hit(s1_r, s1_c);  shape_color = 12'hF00; end
      3'd1: begin shape_lit = diamond_hit(s1_r, s1_c); shape_color = 12'hFF0; end
      3'd2: begin shape_lit = column_hit(s1_r, s1_c);  shape_color = 12'h00F; end
      3'd3: begin shape_lit = column_hit(s1_r, s1_c);  shape_color = 12'h0F0; end
      3'd4: begin shape_lit = diamond_hit(s1_r, s1_c); shape_color = 12'h000; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      on        <= 1'b0;
      color     <= '0;
    end else begin
      out_valid <= s1_valid;
      on        <= s1_lit && shape_lit;
      color     <= (s1_lit && shape_lit) ? shape_color : 12'h000;
    end
  end

endmodule

// File: tb/tb_symbol_row_renderer.sv
// Bench for symbol_row_renderer: main instance (SCALE_LOG2=0, GAP=8,
// BLINK_FRAMES=2) and a scaled instance (SCALE_LOG2=1) sharing all inputs
// except pixel_valid. Expected {on,color} words are pushed when a pixel is
// driven and popped by per-instance monitors on out_valid.
module tb_symbol_row_renderer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  top_left_x = '0, top_left_y = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [2:0]  wr_value = '0;
  logic        hl_en = 1'b0;
  logic [3:0]  hl_idx = '0;
  logic        pixel_valid = 1'b0, pixel_valid_s = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        out_valid, on, out_valid_s, on_s;
  logic [11:0] color, color_s;

  logic [12:0] exp_q[$];
  logic [12:0] exp_s_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [12:0] OFF = 13'h0000;
  localparam logic [12:0] RED = {1'b1, 12'hF00};
  localparam logic [12:0] YEL = {1'b1, 12'hFF0};
  localparam logic [12:0] GRN = {1'b1, 12'h0F0};
  localparam logic [12:0] BLK = {1'b1, 12'h000};

  symbol_row_renderer #(.N_SYM(4), .SCALE_LOG2(0), .GAP(8), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .top_left_x(top_left_x), .top_left_y(top_left_y),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_value(wr_value),
    .hl_en(hl_en), .hl_idx(hl_idx),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .out_valid(out_valid), .on(on), .color(color));

  symbol_row_renderer #(.N_SYM(4), .SCALE_LOG2(1), .GAP(8), .BLINK_FRAMES(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .top_left_x(top_left_x), .top_left_y(top_left_y),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_value(wr_value),
    .hl_en(hl_en), .hl_idx(hl_idx),
    .pixel_valid(pixel_valid_s), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .out_valid(out_valid_s), .on(on_s), .color(color_s));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n     = 1'b0;
    frame_tick  = 1'b0;
    wr_en       = 1'b0;
    pixel_valid = 1'b0;
    pixel_valid_s = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_s_q.delete();
    reset_n = 1'b1;
    #1;
    check("reset_out_valid", {12'b0, out_valid}, OFF);
    check("reset_pixel", {on, color}, OFF);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic tick, input logic we, input logic [3:0] wi,
                       input logic [2:0] wv, input logic pv, input logic to_s,
                       input logic [9:0] x, input logic [9:0] y, input logic [12:0] exp);
    @(negedge clk);
    frame_tick    = tick;
    wr_en         = we;
    wr_idx        = wi;
    wr_value      = wv;
    pixel_x       = x;
    pixel_y       = y;
    pixel_valid   = pv && !to_s;
    pixel_valid_s = pv && to_s;
    if (pv) begin
      if (to_s) exp_s_q.push_back(exp);
      else      exp_q.push_back(exp);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [12:0] exp);
    drive(1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0, x, y, exp);
  endtask
  task automatic pix_s(input logic [9:0] x, input logic [9:0] y, input logic [12:0] exp);
    drive(1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b1, x, y, exp);
  endtask
  task automatic wr(input logic [3:0] i, input logic [2:0] v);
    drive(1'b0, 1'b1, i, v, 1'b0, 1'b0, 10'd0, 10'd0, OFF);
  endtask
  task automatic wr_tick(input logic [3:0] i, input logic [2:0] v);
    drive(1'b1, 1'b1, i, v, 1'b0, 1'b0, 10'd0, 10'd0, OFF);
  endtask
  task automatic tick();
    drive(1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 10'd0, 10'd0, OFF);
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 10'd0, 10'd0, OFF);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL main_unexpected: got %h with no expected entry", {on, color});
      end else begin
        check("main_pixel", {on, color}, exp_q.pop_front());
      end
    end else if (reset_n) begin
      check("main_idle", {on, color}, OFF);
    end
  end

  always @(negedge clk) begin
    if (out_valid_s) begin
      if (exp_s_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scaled_unexpected: got %h with no expected entry", {on_s, color_s});
      end else begin
        check("scaled_pixel", {on_s, color_s}, exp_s_q.pop_front());
      end
    end else if (reset_n) begin
      check("scaled_idle", {on_s, color_s}, OFF);
    end
  end

  // ---------------- stimulus ----------------
  logic blink_exp [6];

  initial begin
    // Phase n = ticks since reset; counter wraps every 2nd tick.
    blink_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    reset_dut();

    // Reset state: all slots blank, origin (0,0).
    pix(10'd2, 10'd2, OFF);

    // Scaling (scaled instance, F=64, stride 72).
    wr(4'd0, 3'd1);
    wr(4'd1, 3'd0);
    tick();
    pix_s(10'd31, 10'd30, YEL);
    pix_s(10'd4,  10'd4,  OFF);
    pix_s(10'd63, 10'd63, OFF);
    pix_s(10'd71, 10'd4,  OFF);   // gap
    pix_s(10'd76, 10'd4,  RED);   // slot 1, r=c=2
    idle();

    reset_dut();

    // Square at origin (100,50).
    wr(4'd0, 3'd0);
    top_left_x = 10'd100;
    top_left_y = 10'd50;
    tick();
    pix(10'd102, 10'd52, RED);
    pix(10'd101, 10'd52, OFF);
    pix(10'd130, 10'd52, OFF);
    pix(10'd129, 10'd79, RED);
    pix(10'd132, 10'd52, OFF);    // gap between slot 0 and 1
    drive(1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 10'd102, 10'd52, OFF); // invalid pixel

    // Commit / tearing.
    wr(4'd1, 3'd1);
    pix(10'd155, 10'd65, OFF);
    tick();
    pix(10'd155, 10'd65, YEL);

    // Write coinciding with commit.
    wr_tick(4'd2, 3'd3);
    pix(10'd190, 10'd65, GRN);
    pix(10'd195, 10'd52, GRN);    // cap row 2, c=15
    pix(10'd194, 10'd52, OFF);    // cap row 2, c=14
    pix(10'd184, 10'd60, OFF);    // outside bar, non-cap row

    // Out-of-range slot write ignored.
    wr(4'd9, 3'd0);
    tick();
    pix(10'd102, 10'd52, RED);
    pix(10'd155, 10'd65, YEL);
    pix(10'd190, 10'd65, GRN);
    pix(10'd235, 10'd65, OFF);

    // Black diamond: lit with color 000.
    wr(4'd3, 3'd4);
    tick();
    pix(10'd235, 10'd65, BLK);

    // Reset mid-stream.
    pix(10'd102, 10'd52, RED);
    pix(10'd102, 10'd52, RED);
    pix(10'd102, 10'd52, RED);
    @(posedge clk);
    #2;
    check("pre_reset_on", {12'b0, on}, 13'd1);
    reset_n = 1'b0;
    #1;
    check("midreset_on", {12'b0, on}, OFF);
    check("midreset_color", {1'b0, color}, OFF);
    check("midreset_out_valid", {12'b0, out_valid}, OFF);
    pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_s_q.delete();
    reset_n = 1'b1;
    top_left_x = 10'd100;
    top_left_y = 10'd50;
    tick();
    pix(10'd102, 10'd52, OFF);
    pix(10'd155, 10'd65, OFF);
    pix(10'd190, 10'd65, OFF);
    pix(10'd235, 10'd65, OFF);
    idle();

    // Blink on slot 0.
    reset_dut();
    hl_en  = 1'b1;
    hl_idx = 4'd0;
    top_left_x = 10'd100;
    top_left_y = 10'd50;
    wr(4'd0, 3'd0);
    for (int n = 0; n < 6; n++) begin
      tick();
`ifdef SYMBOL_ROW_BLINK_EN
      pix(10'd102, 10'd52, blink_exp[n] ? RED : OFF);
`else
      pix(10'd102, 10'd52, RED);
`endif
    end
    idle();

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_s_q.size() != 0); i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d main and %0d scaled expected entries left, required 0",
               exp_q.size(), exp_s_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
